// File: rtl/rs_dispatch_unit_pkg.sv
// Shared types for the Tomasulo issue path: instruction-queue words, register-file read
// results, CDB entries and the reservation-station word, plus the operand resolver.
package tomasula_types;

    localparam int unsigned ROB_DEPTH = 8;
    localparam int unsigned TAG_W     = $clog2(ROB_DEPTH);

    typedef enum logic [6:0] {
        s_op_load  = 7'b0000011,
        s_op_imm   = 7'b0010011,
        s_op_auipc = 7'b0010111,
        s_op_store = 7'b0100011,
        s_op_reg   = 7'b0110011,
        s_op_lui   = 7'b0110111,
        s_op_br    = 7'b1100011,
        s_op_jalr  = 7'b1100111,
        s_op_jal   = 7'b1101111
    } opcode_t;

    typedef struct packed {
        opcode_t     opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        use_imm;
    } iq_word_t;

    typedef struct packed {
        logic [31:0]      data;
        logic             busy;
        logic [TAG_W-1:0] tag;
    } rf_rd_t;

    typedef struct packed {
        logic [31:0] data;
    } cdb_data;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } src_t;

    typedef struct packed {
        opcode_t          opcode;
        logic [2:0]       funct3;
        logic [6:0]       funct7;
        logic [31:0]      pc;
        logic [TAG_W-1:0] rd_tag;
        src_t             src1;
        src_t             src2;
    } res_word;

    // x0 is hard zero; a busy register is satisfied by a same-cycle CDB result for its tag.
    function automatic src_t resolve_src(input logic [4:0] rs, input rf_rd_t rd,
                                         input logic [ROB_DEPTH-1:0] calc,
                                         input cdb_data [ROB_DEPTH-1:0] cdb);
        src_t s;
        s = '0;
        if (rs == 5'd0) begin
            s.valid = 1'b1;
        end else if (!rd.busy) begin
            s.valid = 1'b1;
            s.data  = rd.data;
        end else if (calc[rd.tag]) begin
            s.valid = 1'b1;
            s.data  = cdb[rd.tag].data;
        end else begin
            s.tag = rd.tag;
        end
        return s;
    endfunction

endpackage

// File: rtl/rs_dispatch_unit_if.sv
// Dispatch-unit bus: instruction queue, register file, ROB, CDB and station-side signals.
interface rs_dispatch_unit_if
    import tomasula_types::*;
#(
    parameter int unsigned NUM_RS = 5
);
    logic                           flush;
    logic                           iq_valid;
    iq_word_t                       iq_word;
    logic                           iq_ready;
    logic [4:0]                     rf_rs1;
    logic [4:0]                     rf_rs2;
    rf_rd_t                         rf_rd1;
    rf_rd_t                         rf_rd2;
    logic                           rob_alloc_ready;
    logic [TAG_W-1:0]               rob_alloc_tag;
    logic                           rob_alloc;
    logic                           rf_rename_we;
    logic [4:0]                     rf_rename_rd;
    logic [ROB_DEPTH-1:0]           robs_calculated;
    cdb_data [ROB_DEPTH-1:0]        cdb;
    logic [NUM_RS-1:0]              res_empty;
    logic                           jalr_executed;
    logic [NUM_RS-1:0]              load_word;
    res_word                        res_out;

    modport master (
        input  flush, iq_valid, iq_word, rf_rd1, rf_rd2, rob_alloc_ready, rob_alloc_tag,
               robs_calculated, cdb, res_empty, jalr_executed,
        output iq_ready, rf_rs1, rf_rs2, rob_alloc, rf_rename_we, rf_rename_rd, load_word, res_out
    );

    modport slave (
        output flush, iq_valid, iq_word, rf_rd1, rf_rd2, rob_alloc_ready, rob_alloc_tag,
               robs_calculated, cdb, res_empty, jalr_executed,
        input  iq_ready, rf_rs1, rf_rs2, rob_alloc, rf_rename_we, rf_rename_rd, load_word, res_out
    );
endinterface

// File: rtl/rs_dispatch_unit_rr_select.sv
// Round-robin picker: first empty station at or after ptr, wrapping; one-hot and index out.
module rs_rr_select #(
    parameter  int unsigned NUM_RS = 5,
    localparam int unsigned IDX_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
    input  logic [NUM_RS-1:0] empty,
    input  logic [IDX_W-1:0]  ptr,
    output logic [NUM_RS-1:0] onehot,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);
    int unsigned cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = 0;
        for (int unsigned i = 0; i < NUM_RS; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= NUM_RS) cand = cand - NUM_RS;
            if (!any && empty[IDX_W'(cand)]) begin
                any                  = 1'b1;
                idx                  = IDX_W'(cand);
                onehot[IDX_W'(cand)] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rs_dispatch_unit.sv
// Issue-side writer: holds one decoded word (D), resolves operands and writes it into one
// empty reservation station with a ROB tag; stalls after a JALR until it has executed.
module rs_dispatch_unit
    import tomasula_types::*;
#(
    parameter int unsigned NUM_RS = 5
) (
    input  logic                clk,
    input  logic                rst,
    rs_dispatch_unit_if.master  bus
);
    localparam int unsigned IDX_W = (NUM_RS > 1) ? $clog2(NUM_RS) : 1;

    typedef enum logic [1:0] {IDLE, HOLD, JALR_WAIT} state_t;

    state_t            state;
    iq_word_t          d;
    logic [IDX_W-1:0]  rr_ptr;

    logic [NUM_RS-1:0] sel_onehot;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_any;
    logic              is_jalr, dispatch, iq_ready_c, take;
    src_t              src1, src2;

    rs_rr_select #(.NUM_RS(NUM_RS)) u_sel (
        .empty  (bus.res_empty),
        .ptr    (rr_ptr),
        .onehot (sel_onehot),
        .idx    (sel_idx),
        .any    (sel_any)
    );

    always_comb begin
        is_jalr    = (d.opcode == s_op_jalr);
        dispatch   = ~rst & ~bus.flush & (state == HOLD) & bus.rob_alloc_ready & sel_any;
        iq_ready_c = ~rst & ~bus.flush & ((state == IDLE) | (dispatch & ~is_jalr));
        take       = bus.iq_valid & iq_ready_c;
    end

    always_comb begin
        src1 = resolve_src(d.rs1, bus.rf_rd1, bus.robs_calculated, bus.cdb);
        if (d.opcode == s_op_lui) begin
            src1       = '0;
            src1.valid = 1'b1;
        end else if (d.opcode == s_op_auipc || d.opcode == s_op_jal) begin
            src1       = '0;
            src1.valid = 1'b1;
            src1.data  = d.pc;
        end
        src2 = resolve_src(d.rs2, bus.rf_rd2, bus.robs_calculated, bus.cdb);
        if (d.use_imm) begin
            src2       = '0;
            src2.valid = 1'b1;
            src2.data  = d.imm;
        end
    end

    always_comb begin
        bus.iq_ready     = iq_ready_c;
        bus.rf_rs1       = d.rs1;
        bus.rf_rs2       = d.rs2;
        bus.rob_alloc    = dispatch;
        bus.rf_rename_we = dispatch & (d.rd != 5'd0);
        bus.rf_rename_rd = dispatch ? d.rd : 5'd0;
        bus.load_word    = dispatch ? sel_onehot : '0;
        bus.res_out      = '0;
        if (dispatch) begin
            bus.res_out.opcode = d.opcode;
            bus.res_out.funct3 = d.funct3;
            bus.res_out.funct7 = d.funct7;
            bus.res_out.pc     = d.pc;
            bus.res_out.rd_tag = bus.rob_alloc_tag;
            bus.res_out.src1   = src1;
            bus.res_out.src2   = src2;
        end
    end

    // D is valid exactly while in HOLD, so IDLE/JALR_WAIT double as "D empty".
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            d      <= '0;
            rr_ptr <= '0;
        end else begin
            if (dispatch)
                rr_ptr <= (sel_idx == IDX_W'(NUM_RS - 1)) ? '0 : sel_idx + 1'b1;
            if (bus.flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (take) begin
                        d     <= bus.iq_word;
                        state <= HOLD;
                    end
                    HOLD: if (dispatch) begin
                        if (is_jalr) state <= JALR_WAIT;
                        else if (take) d <= bus.iq_word;
                        else state <= IDLE;
                    end
                    JALR_WAIT: if (bus.jalr_executed) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rs_dispatch_unit.sv
// Directed bench for rs_dispatch_unit: per-cycle vector table plus JALR, ROB-full and flush sequences.
module tb_rs_dispatch_unit;
    import tomasula_types::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs_dispatch_unit_if #(.NUM_RS(5)) bus();
    rs_dispatch_unit #(.NUM_RS(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       nm;
        logic        iv;
        iq_word_t    w;
        rf_rd_t      r1, r2;
        logic        rr;
        logic [2:0]  tg;
        logic [7:0]  calc;
        logic [31:0] c3;
        logic [4:0]  emp;
        logic        fl, jx;
        logic        e_rdy;
        logic [4:0]  e_lw;
        logic        e_ren;
        logic [4:0]  e_rd;
        src_t        e1, e2;
        logic [2:0]  e_tag;
        iq_word_t    ew;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic iq_word_t mkw(input opcode_t op, input logic [4:0] rd, rs1, rs2,
                                     input logic [31:0] imm, pc, input logic ui);
        iq_word_t w;
        w = '0;
        w.opcode = op; w.rd = rd; w.rs1 = rs1; w.rs2 = rs2;
        w.imm = imm; w.pc = pc; w.use_imm = ui;
        return w;
    endfunction

    function automatic rf_rd_t rf(input logic [31:0] dt, input logic b, input logic [2:0] t);
        rf_rd_t r;
        r.data = dt; r.busy = b; r.tag = t;
        return r;
    endfunction

    function automatic src_t sv(input logic [31:0] dt);
        src_t s;
        s = '0; s.valid = 1'b1; s.data = dt;
        return s;
    endfunction

    function automatic src_t si(input logic [2:0] t);
        src_t s;
        s = '0; s.tag = t;
        return s;
    endfunction

    function automatic vec_t mk(input string nm, input logic iv, input iq_word_t w,
        input rf_rd_t r1, r2, input logic rr, input logic [2:0] tg, input logic [7:0] calc,
        input logic [31:0] c3, input logic [4:0] emp, input logic e_rdy, input logic [4:0] e_lw,
        input logic e_ren, input logic [4:0] e_rd, input src_t e1, e2, input logic [2:0] e_tag,
        input iq_word_t ew);
        vec_t v;
        v.nm = nm; v.iv = iv; v.w = w; v.r1 = r1; v.r2 = r2; v.rr = rr; v.tg = tg;
        v.calc = calc; v.c3 = c3; v.emp = emp; v.fl = 1'b0; v.jx = 1'b0;
        v.e_rdy = e_rdy; v.e_lw = e_lw; v.e_ren = e_ren; v.e_rd = e_rd;
        v.e1 = e1; v.e2 = e2; v.e_tag = e_tag; v.ew = ew;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.iq_valid        = v.iv;
        bus.iq_word         = v.w;
        bus.rf_rd1          = v.r1;
        bus.rf_rd2          = v.r2;
        bus.rob_alloc_ready = v.rr;
        bus.rob_alloc_tag   = v.tg;
        bus.robs_calculated = v.calc;
        bus.cdb             = '0;
        bus.cdb[3].data     = v.c3;
        bus.res_empty       = v.emp;
        bus.flush           = v.fl;
        bus.jalr_executed   = v.jx;
    endtask

    task automatic check_row(input vec_t v);
        chk({v.nm, ".iq_ready"},  64'(bus.iq_ready),        64'(v.e_rdy));
        chk({v.nm, ".load_word"}, 64'(bus.load_word),       64'(v.e_lw));
        chk({v.nm, ".rob_alloc"}, 64'(bus.rob_alloc),       64'(|v.e_lw));
        chk({v.nm, ".rename_we"}, 64'(bus.rf_rename_we),    64'(v.e_ren));
        chk({v.nm, ".rename_rd"}, 64'(bus.rf_rename_rd),    64'(v.e_rd));
        chk({v.nm, ".src1"},      64'(bus.res_out.src1),    64'(v.e1));
        chk({v.nm, ".src2"},      64'(bus.res_out.src2),    64'(v.e2));
        chk({v.nm, ".rd_tag"},    64'(bus.res_out.rd_tag),  64'(v.e_tag));
        chk({v.nm, ".opcode"},    64'(bus.res_out.opcode),  64'(v.ew.opcode));
        chk({v.nm, ".pc"},        64'(bus.res_out.pc),      64'(v.ew.pc));
    endtask

    task automatic run(input vec_t v);
        @(negedge clk);
        apply(v);
        #2;
        check_row(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t     tbl[$];
        vec_t     v;
        iq_word_t addi, add, add_b, add_c, junk, lui, auipc, nop, jalr;
        rf_rd_t   nb, b3;

        addi  = mkw(s_op_imm,   5'd1, 5'd0, 5'd0, 32'd5,         32'h100, 1'b1);
        add   = mkw(s_op_reg,   5'd2, 5'd1, 5'd1, 32'd0,         32'h104, 1'b0);
        add_b = mkw(s_op_reg,   5'd2, 5'd1, 5'd1, 32'd0,         32'h108, 1'b0);
        add_c = mkw(s_op_reg,   5'd3, 5'd1, 5'd2, 32'd0,         32'h10C, 1'b0);
        junk  = mkw(s_op_reg,   5'd9, 5'd4, 5'd4, 32'd0,         32'h999, 1'b0);
        lui   = mkw(s_op_lui,   5'd5, 5'd7, 5'd0, 32'h12345000,  32'h200, 1'b1);
        auipc = mkw(s_op_auipc, 5'd6, 5'd9, 5'd0, 32'h1000,      32'h300, 1'b1);
        nop   = mkw(s_op_imm,   5'd0, 5'd0, 5'd0, 32'd0,         32'h400, 1'b1);
        jalr  = mkw(s_op_jalr,  5'd1, 5'd2, 5'd0, 32'd4,         32'h500, 1'b1);
        nb    = rf(32'd0, 1'b0, 3'd0);
        b3    = rf(32'hDEAD, 1'b1, 3'd3);

        tbl.push_back(mk("accept_addi", 1, addi, nb, nb, 1, 0, 0, 0, 5'b11111, 1, 5'b00000, 0, 0, '0, '0, 0, '0));
        tbl.push_back(mk("addi_disp", 0, '0, nb, nb, 1, 3, 0, 0, 5'b11111, 1, 5'b00001, 1, 1, sv(0), sv(5), 3, addi));
        tbl.push_back(mk("accept_add", 1, add, nb, nb, 1, 0, 0, 0, 5'b11111, 1, 5'b00000, 0, 0, '0, '0, 0, '0));
        tbl.push_back(mk("add_pending", 1, add_b, b3, b3, 1, 4, 0, 0, 5'b11111, 1, 5'b00010, 1, 2, si(3), si(3), 4, add));
        tbl.push_back(mk("add_cdb", 0, '0, b3, b3, 1, 5, 8'b00001000, 32'h2A, 5'b11111, 1, 5'b00100, 1, 2, sv(32'h2A), sv(32'h2A), 5, add_b));
        tbl.push_back(mk("accept_add_c", 1, add_c, nb, nb, 1, 0, 0, 0, 5'b11111, 1, 5'b00000, 0, 0, '0, '0, 0, '0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("no_empty", 1, junk, rf(32'h11, 0, 0), rf(32'h22, 0, 0), 1, 6, 0, 0, 5'b00000, 0, 5'b00000, 0, 0, '0, '0, 0, '0));
        tbl.push_back(mk("rr_pick", 0, '0, rf(32'h11, 0, 0), rf(32'h22, 0, 0), 1, 6, 0, 0, 5'b10100, 1, 5'b10000, 1, 3, sv(32'h11), sv(32'h22), 6, add_c));
        tbl.push_back(mk("accept_lui", 1, lui, rf(0, 1, 2), nb, 1, 0, 0, 0, 5'b11111, 1, 5'b00000, 0, 0, '0, '0, 0, '0));
        tbl.push_back(mk("lui_disp", 1, auipc, rf(0, 1, 2), nb, 1, 1, 0, 0, 5'b11111, 1, 5'b00001, 1, 5, sv(0), sv(32'h12345000), 1, lui));
        tbl.push_back(mk("auipc_disp", 0, '0, rf(0, 1, 2), nb, 1, 2, 0, 0, 5'b11111, 1, 5'b00010, 1, 6, sv(32'h300), sv(32'h1000), 2, auipc));
        tbl.push_back(mk("accept_nop", 1, nop, nb, nb, 1, 0, 0, 0, 5'b11111, 1, 5'b00000, 0, 0, '0, '0, 0, '0));
        tbl.push_back(mk("nop_disp", 0, '0, nb, nb, 1, 7, 0, 0, 5'b11111, 1, 5'b00100, 0, 0, sv(0), sv(0), 7, nop));

        // Reset: outputs quiet while rst is high, queue accepted once it drops.
        apply(mk("idle", 0, '0, nb, nb, 1, 0, 0, 0, 5'b11111, 0, 0, 0, 0, '0, '0, 0, '0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset.load_word", 64'(bus.load_word), 64'(0));
        chk("reset.rob_alloc", 64'(bus.rob_alloc), 64'(0));
        chk("reset.iq_ready",  64'(bus.iq_ready),  64'(0));
        rst = 1'b0;
        #1;
        chk("post_reset.iq_ready", 64'(bus.iq_ready), 64'(1));

        foreach (tbl[i]) run(tbl[i]);

        // ROB full while a CDB result for the pending tag arrives; rr_ptr is 3 here.
        run(mk("rob_accept", 1, add, nb, nb, 1, 0, 0, 0, 5'b11111, 1, 5'b00000, 0, 0, '0, '0, 0, '0));
        run(mk("rob_full1", 0, '0, b3, b3, 0, 7, 0, 0, 5'b11111, 0, 5'b00000, 0, 0, '0, '0, 0, '0));
        run(mk("rob_full2", 0, '0, b3, b3, 0, 7, 8'b00001000, 32'h55, 5'b11111, 0, 5'b00000, 0, 0, '0, '0, 0, '0));
        run(mk("rob_free", 0, '0, b3, b3, 1, 7, 8'b00001000, 32'h55, 5'b11111, 1, 5'b01000, 1, 2, sv(32'h55), sv(32'h55), 7, add));

        // JALR blocks the queue until jalr_executed, then dispatch resumes.
        run(mk("jalr_accept", 1, jalr, nb, nb, 1, 0, 0, 0, 5'b11111, 1, 5'b00000, 0, 0, '0, '0, 0, '0));
        run(mk("jalr_disp", 1, add, rf(32'h80, 0, 0), nb, 1, 0, 0, 0, 5'b11111, 0, 5'b10000, 1, 1, sv(32'h80), sv(4), 0, jalr));
        run(mk("jalr_wait1", 1, add, nb, nb, 1, 1, 0, 0, 5'b11111, 0, 5'b00000, 0, 0, '0, '0, 0, '0));
        run(mk("jalr_wait2", 1, add, nb, nb, 1, 1, 0, 0, 5'b11111, 0, 5'b00000, 0, 0, '0, '0, 0, '0));
        v = mk("jalr_exec", 1, add, nb, nb, 1, 1, 0, 0, 5'b11111, 0, 5'b00000, 0, 0, '0, '0, 0, '0);
        v.jx = 1'b1;
        run(v);
        run(mk("jalr_resume", 1, add, nb, nb, 1, 1, 0, 0, 5'b11111, 1, 5'b00000, 0, 0, '0, '0, 0, '0));
        run(mk("jalr_after", 0, '0, nb, nb, 1, 1, 0, 0, 5'b11111, 1, 5'b00001, 1, 2, sv(0), sv(0), 1, add));

        // Flush on a would-dispatch cycle drops D; next cycle is idle.
        run(mk("flush_accept", 1, add_b, nb, nb, 1, 0, 0, 0, 5'b11111, 1, 5'b00000, 0, 0, '0, '0, 0, '0));
        v = mk("flush", 1, add_c, nb, nb, 1, 2, 0, 0, 5'b11111, 0, 5'b00000, 0, 0, '0, '0, 0, '0);
        v.fl = 1'b1;
        run(v);
        run(mk("post_flush", 0, '0, nb, nb, 1, 2, 0, 0, 5'b11111, 1, 5'b00000, 0, 0, '0, '0, 0, '0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
